// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU boot path.
//   loader_state_e : prog_loader FSM state encoding (3-bit, IDLE..ERR)
//   BYTE_W         : width of one stream / RAM data byte
package cpu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_e;

endpackage : cpu_pkg

// File: rtl/prog_loader.sv
// Boot-stage program loader.
// Receives a frame (LEN byte, LEN payload bytes, CSUM byte) on a valid/ready
// byte stream, writes the payload into instruction RAM from LOAD_BASE upward,
// verifies the modulo-256 payload sum and then releases the CPU.
//
// Parameters
//   LOAD_BASE : first RAM address written
//   RUN_EN    : 1 = pulse cpu_run after a good checksum, 0 = stop in DONE
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   start     : begin a load (only honoured in IDLE, DONE, ERR)
//   in_valid  : stream byte valid
//   in_data   : stream byte
//   in_ready  : loader accepts a byte this cycle (state-only)
//   ram_addr  : RAM address (registered)
//   ram_data  : RAM write data (registered)
//   ram_wren  : RAM write enable, one cycle per payload byte
//   cpu_hold  : loader owns the RAM bus, CPU halted
//   cpu_run   : one-cycle run pulse to the stage sequencer
//   done      : last load succeeded
//   err       : last load failed its checksum
module prog_loader
  import cpu_pkg::*;
#(
  parameter logic [BYTE_W-1:0] LOAD_BASE = 8'h00,
  parameter bit                RUN_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [BYTE_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  loader_state_e state_q, state_d;

  // Remaining payload bytes; 9 bits so that LEN=0 can mean 256.
  logic [BYTE_W:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic [BYTE_W-1:0] ram_addr_q, ram_addr_d;
  logic [BYTE_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;

  logic xfer;

  assign xfer = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer && cnt_q == 9'd1) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (xfer) begin
          if (in_data == sum_q) state_d = RUN_EN ? ST_RUN : ST_DONE;
          else                  state_d = ST_ERR;
        end
      end
      ST_RUN:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    cpu_run  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      ST_LEN, ST_DATA, ST_CSUM: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      ST_RUN:  cpu_run = 1'b1;
      ST_DONE: done    = 1'b1;
      // A failed image keeps the CPU halted until a good reload.
      ST_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte counter, running sum, write pointer and registered RAM port
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    ptr_d      = ptr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;

    if (xfer) begin
      unique case (state_q)
        ST_LEN: begin
          cnt_d = (in_data == '0) ? 9'd256 : {1'b0, in_data};
          sum_d = '0;
          ptr_d = LOAD_BASE;
        end
        ST_DATA: begin
          // Write appears one cycle after the transfer; ptr wraps naturally.
          ram_wren_d = 1'b1;
          ram_addr_d = ptr_q;
          ram_data_d = in_data;
          ptr_d      = ptr_q + 8'd1;
          sum_d      = sum_q + in_data;
          cnt_d      = cnt_q - 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      ptr_q      <= LOAD_BASE;
      ram_addr_q <= LOAD_BASE;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      ptr_q      <= ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;

endmodule : prog_loader
